// File: rtl/huffman_code_gen.sv
// Huffman tree reader: walks the finished tree depth-first from a root node and
// emits a right-aligned code and a low-bit mask for every leaf symbol.
module huffman_code_gen #(
  parameter int SYM_NUM     = 6,
  parameter int CODE_W      = 8,
  parameter int STACK_DEPTH = 8,
  parameter int NODE_EMPTY  = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 root_id,
  output logic [3:0]                 tree_sel,
  input  logic [3:0]                 node_l,
  input  logic [3:0]                 node_r,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [SYM_NUM*CODE_W-1:0]  code_o,
  output logic [SYM_NUM*CODE_W-1:0]  mask_o
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] DEPTH_V  = SP_W'(STACK_DEPTH);
  localparam logic [3:0]      SYM_ID   = 4'(SYM_NUM);
  localparam logic [3:0]      EMPTY_ID = 4'(NODE_EMPTY);
  localparam logic [3:0]      LEN_MAX  = 4'(CODE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // A length of zero only happens when the root itself is a leaf; it still
  // needs one valid code bit, hence the single-bit mask.
  function automatic logic [CODE_W-1:0] len_mask(input logic [3:0] len);
    logic [CODE_W-1:0] m;
    m = '0;
    if (len == 4'd0) begin
      m[0] = 1'b1;
    end else begin
      for (int i = 0; i < CODE_W; i++) begin
        m[i] = (i < int'(len));
      end
    end
    return m;
  endfunction

  state_t state_r, state_s;

  logic [3:0]        stack_id_r   [STACK_DEPTH];
  logic [CODE_W-1:0] stack_code_r [STACK_DEPTH];
  logic [3:0]        stack_len_r  [STACK_DEPTH];
  logic [SP_W-1:0]   sp_r;

  logic [CODE_W-1:0] cur_code_r;
  logic [3:0]        cur_len_r;
  logic [3:0]        tree_sel_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [SYM_NUM*CODE_W-1:0] code_r;
  logic [SYM_NUM*CODE_W-1:0] mask_r;

  logic [SP_W-1:0]   sp_dec_s;
  logic [SP_W-1:0]   sp_inc_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic [3:0]        top_id_s;
  logic [CODE_W-1:0] top_code_s;
  logic [3:0]        top_len_s;
  logic              stack_empty_s;
  logic              is_leaf_s;
  logic              is_node_s;
  logic [CODE_W-1:0] code_shl_s;
  logic [3:0]        len_inc_s;
  logic              len_ovf_s;

  // Stack top decode and child prefix arithmetic.
  always_comb begin
    sp_dec_s      = sp_r - SP_W'(1);
    sp_inc_s      = sp_r + SP_W'(1);
    top_idx_s     = sp_dec_s[IDX_W-1:0];
    top_id_s      = stack_id_r[top_idx_s];
    top_code_s    = stack_code_r[top_idx_s];
    top_len_s     = stack_len_r[top_idx_s];
    stack_empty_s = (sp_r == SP_W'(0));
    is_leaf_s     = (top_id_s < SYM_ID);
    is_node_s     = (top_id_s >= SYM_ID) && (top_id_s < EMPTY_ID);
    code_shl_s    = {cur_code_r[CODE_W-2:0], 1'b0};
    len_inc_s     = (cur_len_r == 4'hF) ? 4'hF : (cur_len_r + 4'd1);
    len_ovf_s     = (cur_len_r >= LEN_MAX);
  end

  // Traversal state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP: begin
        if (stack_empty_s) begin
          state_s = DONE;
        end else if (is_node_s) begin
          state_s = WAIT;
        end else begin
          state_s = POP;
        end
      end
      WAIT:    state_s = POP;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Stack, code table and status datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r       <= SP_W'(0);
      cur_code_r <= '0;
      cur_len_r  <= 4'd0;
      tree_sel_r <= SYM_ID;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      code_r     <= '0;
      mask_r     <= '0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            code_r          <= '0;
            mask_r          <= '0;
            err_r           <= 1'b0;
            stack_id_r[0]   <= root_id;
            stack_code_r[0] <= '0;
            stack_len_r[0]  <= 4'd0;
            sp_r            <= SP_W'(1);
          end
        end
        POP: begin
          if (!stack_empty_s) begin
            sp_r <= sp_dec_s;
            if (is_leaf_s) begin
              for (int k = 0; k < SYM_NUM; k++) begin
                if (top_id_s == 4'(k)) begin
                  code_r[k*CODE_W +: CODE_W] <= top_code_s;
                  mask_r[k*CODE_W +: CODE_W] <= len_mask(top_len_s);
                end
              end
            end else if (is_node_s) begin
              tree_sel_r <= top_id_s;
              cur_code_r <= top_code_s;
              cur_len_r  <= top_len_s;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (len_ovf_s) begin
            err_r <= 1'b1;
          end
          // Right child goes in first so the left branch is walked first.
          if (sp_r < DEPTH_V) begin
            stack_id_r[sp_r[IDX_W-1:0]]   <= node_r;
            stack_code_r[sp_r[IDX_W-1:0]] <= code_shl_s | CODE_W'(1);
            stack_len_r[sp_r[IDX_W-1:0]]  <= len_inc_s;
            if (sp_inc_s < DEPTH_V) begin
              stack_id_r[sp_inc_s[IDX_W-1:0]]   <= node_l;
              stack_code_r[sp_inc_s[IDX_W-1:0]] <= code_shl_s;
              stack_len_r[sp_inc_s[IDX_W-1:0]]  <= len_inc_s;
              sp_r <= sp_r + SP_W'(2);
            end else begin
              err_r <= 1'b1;
              sp_r  <= sp_inc_s;
            end
          end else begin
            err_r <= 1'b1;
          end
        end
        DONE: begin
          sp_r <= SP_W'(0);
        end
        default: begin
          sp_r <= SP_W'(0);
        end
      endcase
    end
  end

  assign tree_sel = tree_sel_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign code_o   = code_r;
  assign mask_o   = mask_r;

endmodule

// File: tb/tb_huffman_code_gen.sv
// Directed bench for huffman_code_gen: a table of tree shapes with hand-derived
// codes/masks, plus sequences for restart-while-busy and mid-run reset.
module tb_huffman_code_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  root_id;
  logic [3:0]  tree_sel;
  logic [3:0]  node_l;
  logic [3:0]  node_r;
  logic        busy;
  logic        done;
  logic        err;
  logic [47:0] code_o;
  logic [47:0] mask_o;

  huffman_code_gen dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .root_id  (root_id),
    .tree_sel (tree_sel),
    .node_l   (node_l),
    .node_r   (node_r),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .code_o   (code_o),
    .mask_o   (mask_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tree memory model: outputs follow tree_sel on the falling edge.
  logic [3:0] mem_l [16];
  logic [3:0] mem_r [16];
  always @(negedge clk) begin
    node_l <= mem_l[tree_sel];
    node_r <= mem_r[tree_sel];
  end

  typedef struct packed {
    logic [3:0]  root;
    logic [19:0] l;     // nibble i = left child of node 6+i
    logic [19:0] r;
    logic [47:0] code;  // byte k = symbol k
    logic [47:0] mask;
    logic        err;
    logic [7:0]  cyc;   // cycles from start to done
  } vec_t;

  vec_t vecs [5];
  int n_vec;
  int n_fail;
  logic [3:0] sel_log [$];
  logic [3:0] exp_sel [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_tree(input logic [19:0] l, input logic [19:0] r);
    for (int i = 0; i < 16; i++) begin
      mem_l[i] = 4'hB;
      mem_r[i] = 4'hB;
    end
    for (int i = 0; i < 5; i++) begin
      mem_l[6+i] = l[4*i +: 4];
      mem_r[6+i] = r[4*i +: 4];
    end
  endtask

  // Starts a traversal and watches a fixed 40-cycle window.
  task automatic run(input logic [3:0] root, input int restart_at,
                     output int done_cyc, output int n_done, output logic err1);
    logic [3:0] prev_sel;
    int cyc;
    @(posedge clk); #1;
    root_id = root;
    start   = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    root_id  = 4'd9;
    cyc      = 1;
    done_cyc = 0;
    n_done   = 0;
    err1     = err;
    prev_sel = tree_sel;
    sel_log.delete();
    while (cyc <= 40) begin
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (tree_sel != prev_sel) sel_log.push_back(tree_sel);
      prev_sel = tree_sel;
      start = (cyc == restart_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, nd;
    logic e1;
    n_vec  = 0;
    n_fail = 0;
    //          root   left      right     codes sym5..0          masks sym5..0          err  cyc
    vecs[0] = '{4'd10, 20'h87620, 20'h95431, 48'h03_01_05_04_01_00, 48'h03_03_07_07_07_07, 1'b0, 8'd18};
    vecs[1] = '{4'd10, 20'h98760, 20'h54321, 48'h01_01_01_01_01_00, 48'h01_03_07_0F_1F_1F, 1'b0, 8'd18};
    vecs[2] = '{4'd10, 20'h87B20, 20'h95431, 48'h03_01_05_04_00_00, 48'h03_03_07_07_00_00, 1'b1, 8'd15};
    vecs[3] = '{4'd10, 20'h87620, 20'h95431, 48'h03_01_05_04_01_00, 48'h03_03_07_07_07_07, 1'b0, 8'd18};
    vecs[4] = '{4'd3,  20'h87620, 20'h95431, 48'h00_00_00_00_00_00, 48'h00_00_01_00_00_00, 1'b0, 8'd3};
    exp_sel[0] = 4'd10; exp_sel[1] = 4'd9; exp_sel[2] = 4'd8;
    exp_sel[3] = 4'd7;  exp_sel[4] = 4'd6;

    reset   = 1'b1;
    start   = 1'b0;
    root_id = 4'd0;
    load_tree(vecs[0].l, vecs[0].r);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_tree_sel", 64'(tree_sel), 64'd6);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_code", 64'(code_o), 64'd0);
    chk("rst_mask", 64'(mask_o), 64'd0);

    for (int i = 0; i < 5; i++) begin
      load_tree(vecs[i].l, vecs[i].r);
      run(vecs[i].root, -1, dc, nd, e1);
      chk($sformatf("v%0d_err_cleared", i), 64'(e1), 64'd0);
      chk($sformatf("v%0d_done_cyc", i), 64'(dc), 64'(vecs[i].cyc));
      chk($sformatf("v%0d_done_count", i), 64'(nd), 64'd1);
      chk($sformatf("v%0d_busy_end", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].err));
      chk($sformatf("v%0d_code", i), 64'(code_o), 64'(vecs[i].code));
      chk($sformatf("v%0d_mask", i), 64'(mask_o), 64'(vecs[i].mask));
      if (i == 1) begin
        chk("skew_sel_len", 64'(sel_log.size()), 64'd5);
        for (int j = 0; j < 5 && j < sel_log.size(); j++) begin
          chk($sformatf("skew_sel%0d", j), 64'(sel_log[j]), 64'(exp_sel[j]));
        end
      end
      if (i == 4) begin
        chk("leaf_root_no_sel", 64'(sel_log.size()), 64'd0);
      end
    end

    // Second start at cycle 5 while busy must be ignored.
    load_tree(vecs[0].l, vecs[0].r);
    run(4'd10, 5, dc, nd, e1);
    chk("restart_done_cyc", 64'(dc), 64'd18);
    chk("restart_done_count", 64'(nd), 64'd1);
    chk("restart_code", 64'(code_o), 64'(vecs[0].code));
    chk("restart_mask", 64'(mask_o), 64'(vecs[0].mask));
    chk("restart_err", 64'(err), 64'd0);

    // Reset during cycle 7 of a traversal aborts it without a done pulse.
    load_tree(vecs[2].l, vecs[2].r);
    run(4'd10, -1, dc, nd, e1);
    chk("pre_reset_err", 64'(err), 64'd1);
    load_tree(vecs[0].l, vecs[0].r);
    @(posedge clk); #1;
    root_id = 4'd10;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_tree_sel", 64'(tree_sel), 64'd6);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_code", 64'(code_o), 64'd0);
    chk("abort_mask", 64'(mask_o), 64'd0);
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    chk("abort_quiet", 64'(nd), 64'd0);
    run(4'd10, -1, dc, nd, e1);
    chk("after_abort_done_cyc", 64'(dc), 64'd18);
    chk("after_abort_code", 64'(code_o), 64'(vecs[0].code));
    chk("after_abort_mask", 64'(mask_o), 64'(vecs[0].mask));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
